// File: rtl/nios2_pio_clk_100m_count_gen_pkg.sv
// Shared constants for the 100 MHz cycle-count generator: register map, CONTROL bit layout,
// data width.
package nios2_pio_clk_100m_count_gen_pkg;

    localparam int unsigned DataWidth = 32;

    typedef enum logic [1:0] {
        AddrCount    = 2'd0,
        AddrControl  = 2'd1,
        AddrSnapshot = 2'd2,
        AddrCompare  = 2'd3
    } reg_addr_e;

    localparam int unsigned CtrlRunBit      = 0;
    localparam int unsigned CtrlClearBit    = 1;
    localparam int unsigned CtrlSnapBit     = 2;
    localparam int unsigned CtrlIrqEnBit    = 3;
    localparam int unsigned CtrlMatchClrBit = 4;
    localparam int unsigned CtrlMatchBit    = 31;

endpackage

// File: rtl/pio_cnt_core.sv
// Free-running 32-bit counter with load/clear/enable and wrap, plus the compare-match detect
// (compare logic present only when PIO_CNT_COMPARE_IRQ_EN is defined).
module pio_cnt_core
    import nios2_pio_clk_100m_count_gen_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic                 load,
    input  logic [DataWidth-1:0] load_value,
    input  logic                 clear,
`ifdef PIO_CNT_COMPARE_IRQ_EN
    input  logic [DataWidth-1:0] compare,
    output logic                 hit,
`endif
    output logic [DataWidth-1:0] count
);

    logic [DataWidth-1:0] count_q;
    logic [DataWidth-1:0] count_d;

    // Clear and load override the increment; they never coincide (different addresses).
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_value;
        end else if (run) begin
            count_d = count_q + DataWidth'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

`ifdef PIO_CNT_COMPARE_IRQ_EN
    assign hit = run && (count_q == compare);
`endif

endmodule

// File: rtl/nios2_pio_clk_100m_count_gen.sv
// Avalon-MM slave driving the Nios II input PIO with a 100 MHz cycle count.
// Define PIO_CNT_COMPARE_IRQ_EN to build the COMPARE register, MATCH flag and irq.
module nios2_pio_clk_100m_count_gen
    import nios2_pio_clk_100m_count_gen_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [DataWidth-1:0] writedata,
    output logic [DataWidth-1:0] readdata,
    output logic [DataWidth-1:0] out_port,
    output logic                 irq
);

    logic                 wr_en;
    logic                 wr_count;
    logic                 wr_control;
    logic                 clear;
    logic                 snap;
    logic                 run_q;
    logic [DataWidth-1:0] count;
    logic [DataWidth-1:0] snapshot_q;
    logic [DataWidth-1:0] control_img;
    logic [DataWidth-1:0] compare_val;
    logic [DataWidth-1:0] readdata_d;
    logic [DataWidth-1:0] readdata_q;

    assign wr_en      = chipselect & ~write_n;
    assign wr_count   = wr_en && (address == AddrCount);
    assign wr_control = wr_en && (address == AddrControl);
    assign clear      = wr_control & writedata[CtrlClearBit];
    assign snap       = wr_control & writedata[CtrlSnapBit];

`ifdef PIO_CNT_COMPARE_IRQ_EN
    logic                 wr_compare;
    logic                 match_clr;
    logic                 hit;
    logic                 irq_en_q;
    logic                 match_q;
    logic                 match_d;
    logic [DataWidth-1:0] compare_q;

    assign wr_compare = wr_en && (address == AddrCompare);
    assign match_clr  = wr_control & writedata[CtrlMatchClrBit];
    // A new match wins over a coincident software clear.
    assign match_d    = hit | (match_q & ~match_clr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q  <= 1'b0;
            match_q   <= 1'b0;
            compare_q <= '0;
        end else begin
            match_q <= match_d;
            if (wr_control) begin
                irq_en_q <= writedata[CtrlIrqEnBit];
            end
            if (wr_compare) begin
                compare_q <= writedata;
            end
        end
    end

    assign irq         = match_q & irq_en_q;
    assign compare_val = compare_q;
`else
    assign irq         = 1'b0;
    assign compare_val = '0;
`endif

    pio_cnt_core u_core (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run_q),
        .load       (wr_count),
        .load_value (writedata),
        .clear      (clear),
`ifdef PIO_CNT_COMPARE_IRQ_EN
        .compare    (compare_q),
        .hit        (hit),
`endif
        .count      (count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q      <= 1'b0;
            snapshot_q <= '0;
            readdata_q <= '0;
        end else begin
            readdata_q <= readdata_d;
            if (wr_control) begin
                run_q <= writedata[CtrlRunBit];
            end
            if (snap) begin
                snapshot_q <= count;
            end
        end
    end

    // Strobe bits are never stored, so they always read back as 0.
    always_comb begin
        control_img             = '0;
        control_img[CtrlRunBit] = run_q;
`ifdef PIO_CNT_COMPARE_IRQ_EN
        control_img[CtrlIrqEnBit] = irq_en_q;
        control_img[CtrlMatchBit] = match_q;
`endif
    end

    always_comb begin
        readdata_d = '0;
        case (reg_addr_e'(address))
            AddrCount:    readdata_d = count;
            AddrControl:  readdata_d = control_img;
            AddrSnapshot: readdata_d = snapshot_q;
            AddrCompare:  readdata_d = compare_val;
            default:      readdata_d = '0;
        endcase
    end

    assign readdata = readdata_q;
    assign out_port = count;

endmodule

// File: tb/tb_nios2_pio_clk_100m_count_gen.sv
// Scoreboard bench for the cycle-count generator; expectations are queued per cycle and
// compared one time unit after each rising edge.
module tb_nios2_pio_clk_100m_count_gen;
    import nios2_pio_clk_100m_count_gen_pkg::*;

    localparam int SelOut = 0;
    localparam int SelRd  = 1;
    localparam int SelIrq = 2;

`ifdef PIO_CNT_COMPARE_IRQ_EN
    localparam logic [31:0] MatchExp = 32'h8000_0000;
    localparam logic [31:0] CmpExp   = 32'h0000_0010;
`else
    localparam logic [31:0] MatchExp = 32'h0;
    localparam logic [31:0] CmpExp   = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic [31:0] out_port;
    logic        irq;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
        bit          adv;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    nios2_pio_clk_100m_count_gen dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input bit adv, input int sel, input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        e.adv = adv;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.adv) step();
            case (e.sel)
                SelOut:  obs = out_port;
                SelRd:   obs = readdata;
                default: obs = {31'b0, irq};
            endcase
            check_eq(e.tag, obs, e.val);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        sb_push(0, SelOut, "rst_out", 32'h0);
        sb_push(0, SelRd, "rst_rd", 32'h0);
        sb_push(0, SelIrq, "rst_irq", 32'h0);
        drain();
        reset_n = 1'b1;
        step();

        // Run from zero; readdata on address 0 lags out_port by one cycle.
        bus_write(AddrControl, 32'h1);
        address = AddrCount;
        sb_push(0, SelOut, "run_0", 32'h0);
        for (int k = 1; k <= 3; k++) begin
            sb_push(1, SelOut, $sformatf("run_%0d", k), 32'(k));
            sb_push(0, SelRd, $sformatf("rd_lag_%0d", k), 32'(k - 1));
        end
        drain();

        // Load near the top and watch the wrap.
        bus_write(AddrCount, 32'hFFFF_FFFE);
        sb_push(0, SelOut, "wrap_fe", 32'hFFFF_FFFE);
        sb_push(1, SelOut, "wrap_ff", 32'hFFFF_FFFF);
        sb_push(1, SelOut, "wrap_00", 32'h0000_0000);
        sb_push(1, SelOut, "wrap_01", 32'h0000_0001);
        drain();

        // Snapshot captures the pre-increment value without disturbing the count.
        bus_write(AddrCount, 32'h100);
        bus_write(AddrControl, 32'h5);
        address = AddrSnapshot;
        sb_push(0, SelOut, "snap_cont0", 32'h101);
        sb_push(1, SelOut, "snap_cont1", 32'h102);
        sb_push(0, SelRd, "snap_val", 32'h100);
        drain();

        // Clear with run in the same word; strobe bits read back as 0.
        bus_write(AddrCount, 32'h55);
        bus_write(AddrControl, 32'h3);
        address = AddrControl;
        sb_push(0, SelOut, "clr_0", 32'h0);
        sb_push(1, SelOut, "clr_1", 32'h1);
        sb_push(0, SelRd, "ctrl_rb", 32'h1 | MatchExp);
        drain();

        bus_write(AddrCompare, 32'h10);
        address = AddrCompare;
        sb_push(1, SelRd, "cmp_rb", CmpExp);
        drain();

`ifdef PIO_CNT_COMPARE_IRQ_EN
        bus_write(AddrControl, 32'h12);
        sb_push(0, SelOut, "stop_clr", 32'h0);
        sb_push(0, SelIrq, "irq_cleared", 32'h0);
        drain();
        bus_write(AddrControl, 32'h9);
        sb_push(0, SelOut, "cmp_run_0", 32'h0);
        for (int k = 1; k <= 16; k++) begin
            sb_push(1, SelOut, $sformatf("cmp_run_%0d", k), 32'(k));
        end
        sb_push(0, SelIrq, "irq_before_match", 32'h0);
        sb_push(1, SelOut, "cmp_run_17", 32'h11);
        sb_push(0, SelIrq, "irq_on_match", 32'h1);
        drain();
        bus_write(AddrControl, 32'h19);
        sb_push(0, SelIrq, "irq_match_clr", 32'h0);
        sb_push(0, SelOut, "cmp_run_18", 32'h12);
        drain();
        bus_write(AddrControl, 32'h1);
        bus_write(AddrCount, 32'h10);
        address = AddrControl;
        sb_push(1, SelIrq, "irq_masked", 32'h0);
        sb_push(0, SelRd, "ctrl_nomatch", 32'h1);
        sb_push(1, SelRd, "match_visible", 32'h8000_0001);
        sb_push(0, SelIrq, "irq_masked2", 32'h0);
        drain();
        bus_write(AddrCount, 32'h10);
        bus_write(AddrControl, 32'h19);
        sb_push(0, SelIrq, "set_wins_clr", 32'h1);
        drain();
`else
        sb_push(0, SelIrq, "irq_tied", 32'h0);
        drain();
        bus_write(AddrControl, 32'h19);
        address = AddrControl;
        sb_push(1, SelRd, "ctrl_no_irqen", 32'h1);
        sb_push(0, SelIrq, "irq_tied2", 32'h0);
        drain();
`endif

        // Asynchronous reset mid-count, away from any clock edge.
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        sb_push(0, SelOut, "arst_out", 32'h0);
        sb_push(0, SelRd, "arst_rd", 32'h0);
        sb_push(0, SelIrq, "arst_irq", 32'h0);
        drain();
        #1;
        reset_n = 1'b1;
        address = AddrCount;
        for (int k = 0; k < 3; k++) begin
            sb_push(1, SelOut, $sformatf("hold_%0d", k), 32'h0);
        end
        sb_push(0, SelRd, "hold_rd", 32'h0);
        drain();
        bus_write(AddrControl, 32'h1);
        sb_push(0, SelOut, "rerun_0", 32'h0);
        sb_push(1, SelOut, "rerun_1", 32'h1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nios2_pio_clk_100m_count_gen.md
# nios2_pio_clk_100M_count_gen

Avalon-MM slave that produces the 32-bit free-running 100 MHz cycle count consumed by the Nios II input PIO: the CPU-facing writer/control end of that count path. Holds a run/stop counter, a software load path, a snapshot register and an optional compare-match interrupt. `out_port` connects directly to the input PIO's `in_port`. Sits in the Nios II system on the 100 MHz clock domain.

## Interface
- No parameters; data width fixed at 32.
- `clk`  in  1  100 MHz system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  word address of register.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe; write when `chipselect && !write_n`.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `out_port`  out  32  live count value, registered.
- `irq`  out  1  compare-match interrupt, level (tied 0 when feature compiled out).

## Operation
- Register map: 0 COUNT (rw), 1 CONTROL (rw), 2 SNAPSHOT (ro), 3 COMPARE (rw).
- CONTROL bits: [0] RUN (stored), [1] CLEAR (strobe, reads 0), [2] SNAP (strobe, reads 0), [3] IRQ_EN (stored), [4] MATCH_CLR (strobe, reads 0); read [31] = MATCH flag; other bits read 0, writes ignored.
- Counter: when RUN=1, `count <= count + 1` each cycle, wraps 0xFFFF_FFFF -> 0x0000_0000; RUN=0 holds.
- Write COUNT: loads `writedata`; overrides increment that cycle.
- CLEAR strobe: count <= 0; overrides increment. RUN written in same word takes effect from next cycle (clear and run-enable together: count 0, then 1, 2 ...).
- SNAP strobe: SNAPSHOT <= count value present before that edge (pre-increment).
- MATCH: set on any edge where RUN=1 and count == COMPARE; sticky; cleared by MATCH_CLR; set wins if set and clear coincide.
- `irq` = MATCH & IRQ_EN.
- Read mux: address 0 count, 1 control image, 2 SNAPSHOT, 3 COMPARE; sampled every cycle regardless of chipselect (no read side effects).
- Reset values: count 0, RUN 0, IRQ_EN 0, MATCH 0, SNAPSHOT 0, COMPARE 0, `readdata` 0, `out_port` 0, `irq` 0. Reset mid-count returns all to these immediately (async); counting resumes only after RUN rewritten.

## Timing
- Write effect visible on `out_port`/registers the cycle after the write edge.
- `readdata` latency: 1 cycle after `address` presented (registered, zero wait states).
- `out_port` equals internal count register directly; no extra pipeline stage.
- `irq` asserts 1 cycle after the matching edge's state is registered (combinational from MATCH/IRQ_EN flops).
- Back-to-back writes every cycle supported; no handshake stall.

## Configuration
- `PIO_CNT_COMPARE_IRQ_EN` defined: COMPARE register, MATCH flag, IRQ_EN, MATCH_CLR and `irq` implemented as above.
- Not defined: COMPARE reads 0 and ignores writes; CONTROL bits 3, 4, 31 read 0; `irq` tied 0; no compare logic synthesised.

## Structure
- Shared package: register address constants (COUNT/CONTROL/SNAPSHOT/COMPARE), CONTROL bit-position constants, data width constant.
- One sub-module `pio_cnt_core`: counter with load/clear/enable and wrap, plus match compare; top level holds Avalon decode, CONTROL/SNAPSHOT/COMPARE registers and read mux.

## Test plan
- Reset, then write CONTROL=0x1 -> `out_port` 0,1,2,... from the cycle after write; `readdata` at address 0 tracks count with 1-cycle lag.
- Write COUNT=0xFFFF_FFFE with RUN=1 -> `out_port` 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000, 0x0000_0001.
- Running at count 0x100, write CONTROL=0x5 (RUN+SNAP) -> SNAPSHOT reads 0x100; count continues uninterrupted.
- Write CONTROL=0x3 (RUN+CLEAR) while count=0x55 -> next cycle count 0, then 1; CONTROL readback bit1 = 0.
- (macro on) COMPARE=0x10, CONTROL=0x9 from 0 -> MATCH/`irq` assert after count reaches 0x10; MATCH_CLR write (0x19) deasserts `irq` next cycle; IRQ_EN=0 masks `irq` while MATCH stays readable at bit 31.
- Assert `reset_n` low mid-count -> `out_port`, `readdata`, `irq` to 0 asynchronously; after release count stays 0 until RUN written.
